// File: rtl/tlk2711_cmd_arb.sv
// ---------------------------------------------------------------------------
// tlk2711_cmd_arb
//
// Round-robin arbiter that shares one tlk2711_dma read port between N_CH
// per-link command generators. It grants one channel at a time, latches and
// forwards that channel's {len, addr} command to the DMA, then steers the
// returned read stream to the granted channel until the beat marked last.
//
// Optional feature: define TLK2711_ARB_TIMEOUT_EN to add a 32-bit watchdog
// that abandons a stuck grant after TIMEOUT_CYCLES idle cycles and records
// a sticky per-channel flag in o_timeout_err. Without the macro there is no
// counter, o_timeout_err is tied to zero and i_err_clr is ignored.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_ch_cmd_req        per-channel command request (held until acked)
//   i_ch_cmd_data       channel k command at [k*CW +: CW], {len, addr}
//   o_ch_cmd_ack        one-cycle ack to the granted channel
//   o_cmd_req           command request to the DMA
//   o_cmd_data          latched command of the granted channel
//   i_cmd_ack           DMA command accept
//   i_dma_valid/last/data  DMA read stream in
//   o_dma_ready         ready back to the DMA
//   o_ch_valid          per-channel valid (one-hot or zero)
//   o_ch_last/o_ch_data shared last/data towards the channels
//   i_ch_ready          per-channel ready
//   o_grant             one-hot current owner, zero in IDLE
//   o_busy              high while a command is being issued or transferred
//   i_err_clr           clears o_timeout_err
//   o_timeout_err       sticky per-channel timeout flags
// ---------------------------------------------------------------------------
module tlk2711_cmd_arb #(
    parameter int N_CH           = 4,
    parameter int ADDR_WIDTH     = 48,
    parameter int DLEN_WIDTH     = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_CH-1:0]                      i_ch_cmd_req,
    input  logic [N_CH*(DLEN_WIDTH+ADDR_WIDTH)-1:0] i_ch_cmd_data,
    output logic [N_CH-1:0]                      o_ch_cmd_ack,
    output logic                                 o_cmd_req,
    output logic [DLEN_WIDTH+ADDR_WIDTH-1:0]     o_cmd_data,
    input  logic                                 i_cmd_ack,
    input  logic                                 i_dma_valid,
    input  logic                                 i_dma_last,
    input  logic [DATA_WIDTH-1:0]                i_dma_data,
    output logic                                 o_dma_ready,
    output logic [N_CH-1:0]                      o_ch_valid,
    output logic                                 o_ch_last,
    output logic [DATA_WIDTH-1:0]                o_ch_data,
    input  logic [N_CH-1:0]                      i_ch_ready,
    output logic [N_CH-1:0]                      o_grant,
    output logic                                 o_busy,
    input  logic                                 i_err_clr,
    output logic [N_CH-1:0]                      o_timeout_err
);

    localparam int CW    = DLEN_WIDTH + ADDR_WIDTH;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t            state_q;
    logic [N_CH-1:0]   grant_q;
    logic [N_CH-1:0]   ch_cmd_ack_q;
    logic [IDX_W-1:0]  gidx_q;
    logic [IDX_W-1:0]  last_grant_q;
    logic              cmd_req_q;
    logic [CW-1:0]     cmd_data_q;

    // Round-robin pick: first requester strictly after last_grant, wrapping.
    logic              pick_found_d;
    logic [IDX_W-1:0]  pick_idx_d;
    logic [N_CH-1:0]   pick_onehot_d;
    logic [CW-1:0]     pick_cmd_d;

    always_comb begin
        int k;
        logic [IDX_W-1:0] k_idx;
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        k            = 0;
        k_idx        = '0;
        for (int off = 1; off <= N_CH; off++) begin
            k     = (int'(last_grant_q) + off) % N_CH;
            k_idx = IDX_W'(k);
            if (!pick_found_d && i_ch_cmd_req[k_idx]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = k_idx;
            end
        end
    end

    assign pick_onehot_d = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx_d;
    assign pick_cmd_d    = i_ch_cmd_data[int'(pick_idx_d)*CW +: CW];

    // Stream steering is purely combinational and only open in XFER, so
    // beats arriving at any other time are stalled rather than dropped.
    logic in_xfer;
    logic beat_done;

    assign in_xfer     = (state_q == S_XFER);
    assign o_dma_ready = in_xfer & (|(i_ch_ready & grant_q));
    assign o_ch_valid  = in_xfer ? (grant_q & {N_CH{i_dma_valid}}) : '0;
    assign o_ch_data   = in_xfer ? i_dma_data : '0;
    assign o_ch_last   = in_xfer & i_dma_last;
    assign beat_done   = i_dma_valid & o_dma_ready;

    // Watchdog expiry; constant zero when the feature is compiled out.
    logic to_hit;

`ifdef TLK2711_ARB_TIMEOUT_EN
    logic [31:0]     wdog_q;
    logic [N_CH-1:0] timeout_err_q;

    assign to_hit = (state_q != S_IDLE) && (wdog_q == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q        <= '0;
            timeout_err_q <= '0;
        end else begin
            // Held at zero in IDLE, so a fresh grant always starts from 0.
            if (state_q == S_IDLE || to_hit || beat_done) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + 32'd1;
            end
            // Clear has priority over a same-cycle set.
            timeout_err_q <= (timeout_err_q | (to_hit ? grant_q : '0))
                             & ~{N_CH{i_err_clr}};
        end
    end

    assign o_timeout_err = timeout_err_q;
`else
    logic unused_timeout;

    assign to_hit        = 1'b0;
    assign o_timeout_err = '0;
    assign unused_timeout = &{1'b0, i_err_clr, (TIMEOUT_CYCLES != 0)};
`endif

    // Control FSM with registered grant, command and ack outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_grant_q <= IDX_W'(N_CH - 1);
            cmd_req_q    <= 1'b0;
            cmd_data_q   <= '0;
            ch_cmd_ack_q <= '0;
        end else begin
            ch_cmd_ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found_d) begin
                        state_q    <= S_ISSUE;
                        gidx_q     <= pick_idx_d;
                        grant_q    <= pick_onehot_d;
                        cmd_data_q <= pick_cmd_d;
                        cmd_req_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (to_hit) begin
                        // Give up on the stuck DMA and move the pointer on.
                        state_q      <= S_IDLE;
                        grant_q      <= '0;
                        cmd_req_q    <= 1'b0;
                        last_grant_q <= gidx_q;
                    end else if (i_cmd_ack) begin
                        state_q      <= S_XFER;
                        cmd_req_q    <= 1'b0;
                        ch_cmd_ack_q <= grant_q;
                    end
                end
                S_XFER: begin
                    if (to_hit || (beat_done && i_dma_last)) begin
                        state_q      <= S_IDLE;
                        grant_q      <= '0;
                        last_grant_q <= gidx_q;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    grant_q   <= '0;
                    cmd_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_req    = cmd_req_q;
    assign o_cmd_data   = cmd_data_q;
    assign o_ch_cmd_ack = ch_cmd_ack_q;
    assign o_grant      = grant_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule
